// File: rtl/seven_seg_scan_driver_if.sv
// Front-panel bus for the seven-segment scan driver.
// Display requests flow master -> slave; scanned segment and anode drive flows back.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [6:0]              Seg;
  logic                    Dp;
  logic [NUM_DIGITS-1:0]   An;

  modport master (
    output en, digits, dp_in, blank_mask, blink_mask, lz_en,
    input  Seg, Dp, An
  );

  modport slave (
    input  en, digits, dp_in, blank_mask, blink_mask, lz_en,
    output Seg, Dp, An
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS nibbles onto one active-low
// segment bus with one-cold anodes, plus blanking, blinking, leading-zero suppression and DPs.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  seven_seg_scan_driver_if.slave        bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int REF_W   = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [REF_W-1:0]      ref_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [FRAME_W-1:0]    frame_cnt_r;
  logic                  blink_phase_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;

  logic                  ref_last_s;
  logic                  idx_last_s;
  logic                  frame_last_s;
  logic [3:0]            sel_nibble_s;
  logic                  sel_dp_s;
  logic                  sel_blank_s;
  logic                  sel_blink_s;
  logic                  sel_lz_s;
  logic                  all_zero_s;
  logic [NUM_DIGITS-1:0] lz_sup_s;
  logic                  dark_s;
  logic [6:0]            seg_next_s;
  logic                  dp_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;

  // Codes 10..15 render as letters only when HEX_MODE is set, otherwise dark.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB:    seg = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
      4'hC:    seg = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
      4'hD:    seg = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
      4'hE:    seg = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
      4'hF:    seg = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign ref_last_s   = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
  assign idx_last_s   = (idx_r == IDX_W'(NUM_DIGITS - 1));
  assign frame_last_s = (frame_cnt_r == FRAME_W'(BLINK_FRAMES - 1));

  // Scan timebase: refresh divider, digit index, frame counter and blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_r     <= '0;
      idx_r         <= '0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else begin
      if (ref_last_s) begin
        ref_cnt_r <= '0;
        idx_r     <= idx_last_s ? '0 : idx_r + IDX_W'(1);
        if (idx_last_s) begin
          if (frame_last_s) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
          end else begin
            frame_cnt_r   <= frame_cnt_r + FRAME_W'(1);
          end
        end
      end else begin
        ref_cnt_r <= ref_cnt_r + REF_W'(1);
      end
    end
  end

  // Select the current digit's controls and decide whether it is dark.
  always_comb begin
    sel_nibble_s = 4'h0;
    sel_dp_s     = 1'b0;
    sel_blank_s  = 1'b0;
    sel_blink_s  = 1'b0;
    sel_lz_s     = 1'b0;
    all_zero_s   = 1'b1;
    lz_sup_s     = '0;
    // Walk from the most significant digit down; digit 0 is never suppressed.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero_s  = all_zero_s && (bus.digits[4*i +: 4] == 4'h0);
      lz_sup_s[i] = bus.lz_en && all_zero_s && (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_nibble_s = (idx_r == IDX_W'(i)) ? bus.digits[4*i +: 4] : sel_nibble_s;
      sel_dp_s     = (idx_r == IDX_W'(i)) ? bus.dp_in[i]         : sel_dp_s;
      sel_blank_s  = (idx_r == IDX_W'(i)) ? bus.blank_mask[i]    : sel_blank_s;
      sel_blink_s  = (idx_r == IDX_W'(i)) ? bus.blink_mask[i]    : sel_blink_s;
      sel_lz_s     = (idx_r == IDX_W'(i)) ? lz_sup_s[i]          : sel_lz_s;
    end
    dark_s = sel_blank_s || (sel_blink_s && !blink_phase_r) || sel_lz_s;
  end

  // Next output values; a dark digit keeps its anode so scan timing is unchanged.
  always_comb begin
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    an_next_s  = {NUM_DIGITS{1'b1}};
    if (!bus.en) begin
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
      an_next_s  = {NUM_DIGITS{1'b1}};
    end else if (dark_s) begin
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
      an_next_s  = ~(NUM_DIGITS'(1) << idx_r);
    end else begin
      seg_next_s = decode(sel_nibble_s);
      dp_next_s  = ~sel_dp_s;
      an_next_s  = ~(NUM_DIGITS'(1) << idx_r);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
      an_r  <= an_next_s;
    end
  end

  assign bus.Seg = seg_r;
  assign bus.Dp  = dp_r;
  assign bus.An  = an_r;

endmodule
